// File: rtl/position_update_sequencer_if.sv
// Handshake bundle between the position-update sequencer and its memory/datapath neighbours.
interface position_update_sequencer_if #(
  parameter int AW    = 32,
  parameter int LANES = 1
);
  logic                ready;
  logic                double_buffer;
  logic                stall;
  logic                upd_valid;
  logic [LANES*AW-1:0] raddr;
  logic                rd_valid;
  logic [LANES*AW-1:0] waddr;
  logic                we;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output ready, double_buffer, stall, upd_valid,
    input  raddr, rd_valid, waddr, we, busy, done, err
  );

  modport slave (
    input  ready, double_buffer, stall, upd_valid,
    output raddr, rd_valid, waddr, we, busy, done, err
  );
endinterface

// File: rtl/position_update_sequencer.sv
// Sweeps LANES-wide reads over the active half of the position buffer and issues overwrite
// addresses into the inactive half as updates return (1-cycle write latency, stall holds reads).
module position_update_sequencer #(
  parameter int DBSIZE = 256,
  parameter int AW     = 32,
  parameter int LANES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  position_update_sequencer_if.slave bus
);
  localparam int CW = $clog2(DBSIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(DBSIZE - LANES);
  localparam logic [CW-1:0] FULL = CW'(DBSIZE);
  localparam logic [CW-1:0] STEP = CW'(LANES);
  localparam logic [AW-1:0] HALF = AW'(DBSIZE);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       ridx, wcnt, rcnt;
  logic                db, rd_valid, we, err;
  logic [LANES*AW-1:0] raddr, waddr, waddr_next;
  logic [AW-1:0]       rbase, wbase;
  logic                rd_fire, rd_last, wr_full;

  assign rbase   = db ? HALF : '0;
  assign wbase   = db ? '0 : HALF;
  assign rd_fire = (state == RUN) && rd_valid && !bus.stall;
  assign rd_last = rd_fire && (ridx == LAST);
  assign wr_full = (wcnt == FULL);

  always_comb begin
    raddr      = '0;
    waddr_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rd_valid) raddr[i*AW +: AW] = rbase + AW'(ridx) + AW'(i);
      waddr_next[i*AW +: AW] = wbase + AW'(wcnt) + AW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!bus.ready) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  state_next = RUN;
        // wr_full here means the final write is on the bus now (or already went out early)
        RUN:   if (rd_last) state_next = wr_full ? DONE : FLUSH;
        FLUSH: if (wr_full) state_next = DONE;
        DONE:  state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ridx     <= '0;
      wcnt     <= '0;
      rcnt     <= '0;
      db       <= 1'b0;
      rd_valid <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      err      <= 1'b0;
    end else if (!bus.ready) begin
      ridx     <= '0;
      wcnt     <= '0;
      rcnt     <= '0;
      rd_valid <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          db       <= bus.double_buffer;
          ridx     <= '0;
          wcnt     <= '0;
          rcnt     <= '0;
          rd_valid <= 1'b1;
          we       <= 1'b0;
        end
        RUN, FLUSH: begin
          if (rd_fire) begin
            rcnt <= rcnt + STEP;
            if (ridx == LAST) rd_valid <= 1'b0;
            else              ridx     <= ridx + STEP;
          end
          we <= 1'b0;
          if (bus.upd_valid) begin
            if (wr_full) begin
              err <= 1'b1;
            end else begin
              // a write may only target slots whose reads were consumed on an earlier edge
              if (wcnt >= rcnt) err <= 1'b1;
              we    <= 1'b1;
              waddr <= waddr_next;
              wcnt  <= wcnt + STEP;
            end
          end
        end
        default: begin
          rd_valid <= 1'b0;
          we       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.raddr    = raddr;
  assign bus.rd_valid = rd_valid;
  assign bus.waddr    = waddr;
  assign bus.we       = we;
  assign bus.err      = err;
  assign bus.busy     = (state == RUN) || (state == FLUSH);
  assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_position_update_sequencer.sv
// Directed bench: a vector table for the 2-lane full pass plus hand sequences on a 1-lane instance.
module tb_position_update_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  position_update_sequencer_if #(.AW(32), .LANES(2)) b2 ();
  position_update_sequencer_if #(.AW(32), .LANES(1)) b1 ();

  position_update_sequencer #(.DBSIZE(8), .AW(32), .LANES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  position_update_sequencer #(.DBSIZE(8), .AW(32), .LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic        rst, ready, db, stall, upd;
    logic        rv;
    logic [63:0] ra;
    logic        we;
    logic [63:0] wa;
    logic        busy, done, err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, rdy, d, st, up, rv,
                              input logic [31:0] ra0, input logic w, input logic [31:0] wa0,
                              input logic bsy, dn, er);
    vec_t v;
    v.rst = r; v.ready = rdy; v.db = d; v.stall = st; v.upd = up;
    v.rv = rv;
    v.ra = rv ? {ra0 + 32'd1, ra0} : 64'd0;
    v.we = w;
    v.wa = w ? {wa0 + 32'd1, wa0} : 64'd0;
    v.busy = bsy; v.done = dn; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b2.ready = 0; b2.double_buffer = 0; b2.stall = 0; b2.upd_valid = 0;
    b1.ready = 0; b1.double_buffer = 0; b1.stall = 0; b1.upd_valid = 0;
    step();
    step();

    //          rst rdy db st up | rv ra  we wa  busy done err
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 0,  0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2,  0, 0,  1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  0, 0,  0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 0,  0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2,  0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 4,  0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1,  1, 6,  1, 8,  1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1,  0, 0,  1, 10, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1,  0, 0,  1, 12, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1,  0, 0,  1, 14, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  0, 0,  0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  0, 0,  0, 0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst;
      b2.ready = tbl[k].ready; b2.double_buffer = tbl[k].db;
      b2.stall = tbl[k].stall; b2.upd_valid = tbl[k].upd;
      step();
      chk($sformatf("row%0d rd_valid", k), 64'(b2.rd_valid), 64'(tbl[k].rv));
      chk($sformatf("row%0d we", k), 64'(b2.we), 64'(tbl[k].we));
      chk($sformatf("row%0d busy", k), 64'(b2.busy), 64'(tbl[k].busy));
      chk($sformatf("row%0d done", k), 64'(b2.done), 64'(tbl[k].done));
      chk($sformatf("row%0d err", k), 64'(b2.err), 64'(tbl[k].err));
      if (tbl[k].rv || tbl[k].rst) chk($sformatf("row%0d raddr", k), b2.raddr, tbl[k].ra);
      if (tbl[k].we || tbl[k].rst) chk($sformatf("row%0d waddr", k), b2.waddr, tbl[k].wa);
    end

    // upper-half read pass with a mid-pass double_buffer toggle, ending with one surplus update
    b1.ready = 1; b1.double_buffer = 1;
    step();
    chk("db1 first rd_valid", 64'(b1.rd_valid), 64'd1);
    chk("db1 first raddr", 64'(b1.raddr), 64'd8);
    for (int c = 1; c <= 10; c++) begin
      b1.double_buffer = (c >= 4) ? 1'b0 : 1'b1;
      b1.upd_valid = (c >= 2);
      step();
      chk($sformatf("db1 c%0d rd_valid", c), 64'(b1.rd_valid), 64'(c <= 7));
      if (c <= 7) chk($sformatf("db1 c%0d raddr", c), 64'(b1.raddr), 64'(8 + c));
      chk($sformatf("db1 c%0d we", c), 64'(b1.we), 64'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk($sformatf("db1 c%0d waddr", c), 64'(b1.waddr), 64'(c - 2));
      chk($sformatf("db1 c%0d busy", c), 64'(b1.busy), 64'(c <= 9));
      chk($sformatf("db1 c%0d done", c), 64'(b1.done), 64'(c == 10));
      chk($sformatf("db1 c%0d err", c), 64'(b1.err), 64'(c == 10));
    end
    b1.upd_valid = 0; b1.ready = 0;
    step();
    chk("db1 idle done", 64'(b1.done), 64'd0);
    chk("db1 idle busy", 64'(b1.busy), 64'd0);
    chk("db1 err sticky", 64'(b1.err), 64'd1);

    // stall holds beat 4 for three cycles
    b1.ready = 1; b1.double_buffer = 0;
    step();
    chk("stall c0 raddr", 64'(b1.raddr), 64'd0);
    for (int c = 1; c <= 8; c++) begin
      b1.stall = (c >= 5 && c <= 7);
      step();
      chk($sformatf("stall c%0d rd_valid", c), 64'(b1.rd_valid), 64'd1);
      chk($sformatf("stall c%0d raddr", c), 64'(b1.raddr), 64'((c <= 4) ? c : ((c <= 7) ? 4 : 5)));
    end
    b1.stall = 0;

    // abort after three consumed reads, then restart in the other half
    b1.ready = 0;
    step();
    b1.ready = 1;
    step();
    for (int c = 1; c <= 3; c++) begin
      b1.upd_valid = (c == 3);
      step();
      chk($sformatf("abort c%0d raddr", c), 64'(b1.raddr), 64'(c));
    end
    chk("abort pre we", 64'(b1.we), 64'd1);
    chk("abort pre waddr", 64'(b1.waddr), 64'd8);
    b1.upd_valid = 0; b1.ready = 0;
    step();
    chk("abort rd_valid", 64'(b1.rd_valid), 64'd0);
    chk("abort we", 64'(b1.we), 64'd0);
    chk("abort done", 64'(b1.done), 64'd0);
    chk("abort busy", 64'(b1.busy), 64'd0);
    b1.ready = 1; b1.double_buffer = 1;
    step();
    chk("restart rd_valid", 64'(b1.rd_valid), 64'd1);
    chk("restart raddr", 64'(b1.raddr), 64'd8);

    // update arriving before any read has been consumed
    b1.ready = 0; rst = 1;
    step();
    chk("rst clears err", 64'(b1.err), 64'd0);
    chk("rst rd_valid", 64'(b1.rd_valid), 64'd0);
    rst = 0; b1.ready = 1; b1.double_buffer = 0;
    step();
    b1.upd_valid = 1;
    step();
    chk("early write err", 64'(b1.err), 64'd1);
    chk("early write we", 64'(b1.we), 64'd1);
    chk("early write waddr", 64'(b1.waddr), 64'd8);
    b1.upd_valid = 0; b1.ready = 0;
    step();
    step();
    chk("early err sticky", 64'(b1.err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
